led_anim_sched: RTL

Scheduler and controller for the 8-LED bar animation datapath. It accepts a configuration (pattern mode, step period, loop flag) through a valid/ready handshake, then owns the step timer. On start it sequences the selected pattern onto the LED bus, one step per period. It sits between the host/config logic and the LED pins, replacing free-running per-pattern state machines.

---
 rtl/led_anim_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/led_anim_sched.sv
// led_anim_sched: configuration handshake, step timer and pattern sequencer
// for an 8-LED bar. A run walks the selected pattern onto `out`, one step per
// period, either once (ending with a done pulse) or forever.
// Optional build macro ANIM_PAUSE_EN adds a `pause` input that freezes RUN.
module led_anim_sched #(
    parameter int               PRE_W      = 16,
    parameter logic [PRE_W-1:0] DEF_PERIOD = 16'd1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [PRE_W-1:0] cfg_period,
    input  logic             cfg_loop,
    input  logic             start,
    input  logic             stop,
`ifdef ANIM_PAUSE_EN
    input  logic             pause,
`endif
    output logic             busy,
    output logic             done,
    output logic             step_tick,
    output logic [3:0]       step_idx,
    output logic [7:0]       out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] M_FILL   = 2'd0;
    localparam logic [1:0] M_CHASE  = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       mode_cur;
    logic [PRE_W-1:0] period_cur;
    logic             loop_cur;
    logic [PRE_W-1:0] cnt;
    logic [PRE_W-1:0] reload;
    logic [3:0]       last_idx;
    logic             pause_act;
    logic             cnt_zero;

    // LED value for a given pattern and step index
    function automatic logic [7:0] pattern(input logic [1:0] mode, input logic [3:0] idx);
        logic [7:0] val;
        val = 8'h00;
        case (mode)
            M_FILL: begin
                case (idx)
                    4'd0:  val = 8'h01;
                    4'd1:  val = 8'h03;
                    4'd2:  val = 8'h07;
                    4'd3:  val = 8'h0F;
                    4'd4:  val = 8'h1F;
                    4'd5:  val = 8'h3F;
                    4'd6:  val = 8'h7F;
                    4'd7:  val = 8'hFF;
                    4'd8:  val = 8'h7F;
                    4'd9:  val = 8'h3F;
                    4'd10: val = 8'h1F;
                    4'd11: val = 8'h0F;
                    4'd12: val = 8'h07;
                    4'd13: val = 8'h03;
                    4'd14: val = 8'h01;
                    default: val = 8'h00;
                endcase
            end
            M_CHASE: val = 8'h01 << idx[2:0];
            M_BOUNCE: begin
                case (idx)
                    4'd0:  val = 8'h01;
                    4'd1:  val = 8'h02;
                    4'd2:  val = 8'h04;
                    4'd3:  val = 8'h08;
                    4'd4:  val = 8'h10;
                    4'd5:  val = 8'h20;
                    4'd6:  val = 8'h40;
                    4'd7:  val = 8'h80;
                    4'd8:  val = 8'h40;
                    4'd9:  val = 8'h20;
                    4'd10: val = 8'h10;
                    4'd11: val = 8'h08;
                    4'd12: val = 8'h04;
                    4'd13: val = 8'h02;
                    default: val = 8'h00;
                endcase
            end
            default: val = idx[0] ? 8'h00 : 8'hFF;
        endcase
        return val;
    endfunction

    // Index of the final step of each pattern
    function automatic logic [3:0] last_step(input logic [1:0] mode);
        case (mode)
            M_FILL:   return 4'd15;
            M_CHASE:  return 4'd7;
            M_BOUNCE: return 4'd13;
            default:  return 4'd1;
        endcase
    endfunction

`ifdef ANIM_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    // A period of 0 behaves as 1, so the reload value bottoms out at 0
    assign reload   = (period_cur == '0) ? '0 : period_cur - PRE_W'(1);
    assign last_idx = last_step(mode_cur);
    assign cnt_zero = (cnt == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs; stop outranks tick and start
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_ready = 1'b0;
        step_tick = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (start && !stop) state_nxt = S_ARM;
            end
            S_ARM: begin
                busy      = 1'b1;
                state_nxt = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (!pause_act && cnt_zero) begin
                    step_tick = 1'b1;
                    if (step_idx == last_idx && !loop_cur) state_nxt = S_DONE;
                end
            end
            default: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Configuration registers; a held-off offer is taken on the first IDLE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_cur   <= M_FILL;
            period_cur <= DEF_PERIOD;
            loop_cur   <= 1'b0;
        end else if (state == S_IDLE && cfg_valid) begin
            mode_cur   <= cfg_mode;
            period_cur <= cfg_period;
            loop_cur   <= cfg_loop;
        end
    end

    // Step timer, step index and LED output sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            step_idx <= 4'd0;
            out      <= 8'h00;
        end else begin
            case (state)
                S_ARM: begin
                    step_idx <= 4'd0;
                    if (stop) begin
                        out <= 8'h00;
                    end else begin
                        cnt <= reload;
                        out <= pattern(mode_cur, 4'd0);
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        out      <= 8'h00;
                        step_idx <= 4'd0;
                    end else if (!pause_act) begin
                        if (cnt_zero) begin
                            cnt <= reload;
                            if (step_idx == last_idx) begin
                                if (loop_cur) begin
                                    step_idx <= 4'd0;
                                    out      <= pattern(mode_cur, 4'd0);
                                end
                            end else begin
                                step_idx <= step_idx + 4'd1;
                                out      <= pattern(mode_cur, step_idx + 4'd1);
                            end
                        end else begin
                            cnt <= cnt - PRE_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    out      <= 8'h00;
                    step_idx <= 4'd0;
                end
                default: ;
            endcase
        end
    end

endmodule
